// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] MAX_DIGIT = 4'd9;
  localparam logic [NIBBLE_W-1:0] DD_CORR   = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  function automatic logic is_valid_bcd(input logic [NIBBLE_W-1:0] nib);
    return nib <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_nibble_corr.sv
// Reverse double-dabble correction: one nibble, minus DD_CORR when >= 8.
module bcd_nibble_corr
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd8) dout = din - DD_CORR;
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter with start/done handshake.
// Optional signed output enabled by macro BCD2BIN_SIGN_EN.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [4*DIGITS-1:0]      bcd_i,
`ifdef BCD2BIN_SIGN_EN
  input  logic                     sign_i,
  output logic [BIN_W:0]           bin_o,
`else
  output logic [BIN_W-1:0]         bin_o,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     err_o
);

  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
`ifdef BCD2BIN_SIGN_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif

  state_t           state;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_corr;
  logic [BIN_W-1:0] bin_sr;
  logic [CNT_W-1:0] cnt;
  logic             invalid;
  logic             bcd_ok;
  logic             fin_err;
  logic [OUT_W-1:0] fin_bin;
`ifdef BCD2BIN_SIGN_EN
  logic             sign_r;
`endif

  always_comb begin
    bcd_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!is_valid_bcd(bcd_i[i*NIBBLE_W +: NIBBLE_W])) bcd_ok = 1'b0;
    end
  end

  // LSB of bcd_sr moves into bin_sr; the shifted BCD word is then corrected.
  assign bcd_shift = {1'b0, bcd_sr[BCD_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_nibble_corr u_corr (
      .din  (bcd_shift[g*NIBBLE_W +: NIBBLE_W]),
      .dout (bcd_corr[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  // A residue left in bcd_sr after all shifts means the value overflowed BIN_W.
  assign fin_err = invalid | (|bcd_sr);

  always_comb begin
    fin_bin = '0;
    if (!fin_err) begin
`ifdef BCD2BIN_SIGN_EN
      fin_bin = {1'b0, bin_sr};
      if (sign_r && (|bin_sr)) fin_bin = -{1'b0, bin_sr};
`else
      fin_bin = bin_sr;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_o   <= '0;
      err_o   <= 1'b0;
      cnt     <= '0;
      bcd_sr  <= '0;
      bin_sr  <= '0;
      invalid <= 1'b0;
`ifdef BCD2BIN_SIGN_EN
      sign_r  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_sr  <= bcd_ok ? bcd_i : '0;
            bin_sr  <= '0;
            cnt     <= '0;
            invalid <= !bcd_ok;
`ifdef BCD2BIN_SIGN_EN
            sign_r  <= sign_i;
`endif
            if (bcd_ok) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= FIN;
            end
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_corr;
          bin_sr <= {bcd_sr[0], bin_sr[BIN_W-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          bin_o <= fin_bin;
          err_o <= fin_err;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq against a decimal arithmetic model.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
`ifdef BCD2BIN_SIGN_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [15:0]      bcd_i = '0;
  logic             busy;
  logic             done;
  logic             err_o;
  logic [OUT_W-1:0] bin_o;
`ifdef BCD2BIN_SIGN_EN
  logic             sign_i = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_i  (bcd_i),
`ifdef BCD2BIN_SIGN_EN
    .sign_i (sign_i),
`endif
    .bin_o  (bin_o),
    .busy   (busy),
    .done   (done),
    .err_o  (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the digits, range check, optional negation.
  function automatic void model(input logic [15:0] bcd, input logic sgn,
                                output logic [OUT_W-1:0] eb, output logic ee,
                                output logic inv);
    int unsigned val = 0;
    int unsigned p   = 1;
    inv = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      int unsigned d = (32'(bcd) >> (4 * i)) & 32'hF;
      if (d > 9) inv = 1'b1;
      val += d * p;
      p   *= 10;
    end
    ee = inv || (val >= (32'd1 << BIN_W));
    eb = '0;
    if (!ee) begin
      eb = OUT_W'(val);
      if (sgn && val != 0) eb = OUT_W'(0 - val);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done (bounded); returns edges taken.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 60);
  endtask

  task automatic run(input string tag, input logic [15:0] bcd, input logic sgn);
    logic [OUT_W-1:0] eb;
    logic ee, inv;
    int lat;
    model(bcd, sgn, eb, ee, inv);
    bcd_i = bcd;
`ifdef BCD2BIN_SIGN_EN
    sign_i = sgn;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    bcd_i = 16'($urandom);
`ifdef BCD2BIN_SIGN_EN
    sign_i = ~sgn;
`endif
    check({tag, " busy"}, 32'(busy), 32'(!inv));
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), inv ? 32'd1 : 32'(BIN_W + 1));
    check({tag, " bin"}, 32'(bin_o), 32'(eb));
    check({tag, " err"}, 32'(err_o), 32'(ee));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    tick();
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int n_done;
    logic [15:0] w;

    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset bin", 32'(bin_o), 32'd0);
    check("reset err", 32'(err_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    run("h1234", 16'h1234, 1'b0);
    check("h1234 value", 32'(bin_o), 32'h04D2);
    run("h9999", 16'h9999, 1'b0);
    check("h9999 value", 32'(bin_o), 32'h270F);
    run("h0000", 16'h0000, 1'b0);
    run("h12A4", 16'h12A4, 1'b0);
    run("h0007", 16'h0007, 1'b0);

    // Start during busy must be ignored.
    bcd_i = 16'h0500;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bcd_i = 16'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("ignore latency", 32'(lat), 32'(BIN_W + 1 - 5));
    check("ignore bin", 32'(bin_o), 32'd500);
    n_done = 0;
    repeat (20) begin
      tick();
      if (done) n_done++;
    end
    check("ignore no second done", 32'(n_done), 32'd0);
    check("ignore bin held", 32'(bin_o), 32'd500);

    // Reset mid-conversion aborts without a done pulse.
    bcd_i = 16'h4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort bin", 32'(bin_o), 32'd0);
    check("abort err", 32'(err_o), 32'd0);
    n_done = 0;
    repeat (2) begin
      tick();
      if (done) n_done++;
    end
    rst = 1'b1;
    repeat (20) begin
      tick();
      if (done) n_done++;
    end
    check("abort no done", 32'(n_done), 32'd0);
    run("h0042", 16'h0042, 1'b0);
    check("h0042 value", 32'(bin_o), 32'd42);

    // Held start: back-to-back conversions every BIN_W+2 cycles.
    bcd_i = 16'h0123;
    start = 1'b1;
    wait_done(lat);
    check("held first bin", 32'(bin_o), 32'd123);
    wait_done(lat);
    start = 1'b0;
    check("held period", 32'(lat), 32'(BIN_W + 2));
    check("held second bin", 32'(bin_o), 32'd123);
    repeat (3) tick();

    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 3) begin
        w = 16'($urandom);
      end else begin
        for (int d = 0; d < DIGITS; d++) w[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      run($sformatf("rand%0d", i), w, 1'b0);
    end

`ifdef BCD2BIN_SIGN_EN
    run("neg250", 16'h0250, 1'b1);
    check("neg250 value", 32'(bin_o), 32'h7F06);
    run("negzero", 16'h0000, 1'b1);
    check("negzero value", 32'(bin_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < DIGITS; d++) w[4*d +: 4] = 4'($urandom_range(0, 9));
      run($sformatf("srand%0d", i), w, 1'($urandom));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter. It is the decoding counterpart of the binary-to-BCD path that feeds the 7-segment display.
Takes a packed multi-digit BCD word (keypad-entered decimal operand) and produces its binary value using iterative reverse double-dabble: shift right one bit per cycle, then subtract 3 from every nibble >= 8.
Sits between operand entry and the Booth multiplier operand registers, handshaking with start/done.

Parameters:
DIGITS, 4, number of BCD digits in bcd_i
BIN_W, 14, width of binary result; also the number of shift iterations (14 bits cover 9999)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request a conversion; sampled only in IDLE
bcd_i  in  4*DIGITS  packed BCD, digit 0 in [3:0]
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when bin_o/err_o are valid
bin_o  out  BIN_W  binary result; held until the next done
err_o  out  1  invalid-digit or overflow flag; valid with done, held

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, bin_o=0, err_o=0, iteration counter=0, internal shift registers=0.
- FSM states: IDLE, SHIFT, FIN.
- IDLE, start=1 (edge T):
  - If any nibble of bcd_i > 9: go to FIN with invalid flag set.
  - Otherwise: load the BCD shift register with bcd_i, clear the binary shift register, set counter=0, go to SHIFT.
  - busy=1 from T+1.
- SHIFT, each cycle:
  - Shift the concatenation {bcd_sr, bin_sr} right by 1 (LSB of bcd_sr enters MSB of bin_sr).
  - Then each nibble of the shifted bcd_sr that is >= 8 has 3 subtracted (4-bit, no borrow between nibbles).
  - Increment counter. After BIN_W shift cycles, go to FIN.
- FIN (one cycle):
  - done=1, busy=0.
  - bin_o <= bin_sr.
  - err_o <= invalid flag OR (bcd_sr != 0), where a nonzero residue means overflow.
  - On error, bin_o <= 0.
  - Next state is IDLE.
- Latency, valid input: done is high in cycle T+BIN_W+1 (T+15 at defaults).
- Latency, invalid digit: done is high in cycle T+1.
- start while busy, or in FIN: ignored, not queued.
- start held high: a new conversion is accepted in the IDLE cycle right after FIN (back-to-back throughput BIN_W+2 cycles).
- bin_o and err_o change only in FIN; they are stable between done pulses.
- bcd_i is sampled only at acceptance; later changes have no effect on the conversion in progress.
- Reset asserted mid-conversion: immediate return to IDLE with reset values. No done pulse for the aborted operation.

Optional Feature:
- Macro: BCD2BIN_SIGN_EN.
- Defined:
  - Adds input sign_i (1 bit), sampled together with bcd_i.
  - bin_o widens to BIN_W+1 and is the two's-complement result: negated in FIN when sign_i=1 and the magnitude is nonzero.
  - Negative zero yields 0.
- Not defined: no sign_i port; bin_o is the unsigned BIN_W-bit magnitude.

Decomposition:
- Package bcd_pkg:
  - state enum typedef (IDLE/SHIFT/FIN)
  - localparams NIBBLE_W=4, MAX_DIGIT=9, DD_CORR=3
  - function is_valid_bcd (per-nibble check)
- Sub-module bcd_nibble_corr: combinational, 4-bit in/out, subtracts DD_CORR when in >= 8. Instantiated DIGITS times by generate inside the SHIFT datapath.

Test Plan:
- bcd_i=16'h1234, start pulse at T -> busy=1 from T+1; done=1 at T+15; bin_o=14'd1234 (0x04D2); err_o=0.
- bcd_i=16'h9999 -> bin_o=9999 (0x270F), err_o=0. Then bcd_i=16'h0000 -> bin_o=0, err_o=0.
- bcd_i=16'h12A4 -> done at T+1, err_o=1, bin_o=0. Next conversion of 16'h0007 -> bin_o=7, err_o=0.
- Start 16'h0500, then pulse start with 16'h0001 at T+5 -> that start is ignored; done only at T+15 with bin_o=500; no second done.
- Start 16'h4321, drive rst=0 at T+7 for 2 cycles -> outputs immediately 0, no done. Fresh start of 16'h0042 -> bin_o=42.
- BCD2BIN_SIGN_EN, sign_i=1, bcd_i=16'h0250 -> bin_o=15'h7F06 (-250). sign_i=1, bcd_i=0 -> bin_o=0.
